// File: rtl/tage_hist_hash.sv
// tage_hist_hash: speculative/architectural global history with incrementally
// folded index and tag registers, producing a registered TAGE index and tag.
// Optional feature: define TAGE_HIST_DOMAIN_FLUSH_EN to flush both histories
// whenever a lookup arrives from a domain other than the last captured one.
`ifndef TAGE_IDX_WIDTH
`define TAGE_IDX_WIDTH 10
`endif

package tage_hist_hash_pkg;
  typedef enum logic [1:0] {
    INIT = 2'd0,
    D0   = 2'd1,
    D1   = 2'd2,
    D2   = 2'd3
  } domain_t;
endpackage

module tage_hist_hash
  import tage_hist_hash_pkg::*;
#(
  parameter int HIST_LEN = 64,
  parameter int IDX_W    = `TAGE_IDX_WIDTH,
  parameter int TAG_W    = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lookup_valid_i,
  input  logic [31:0]      pc_i,
  input  domain_t          domain_i,
  input  logic             spec_push_i,
  input  logic             spec_dir_i,
  input  logic             ret_valid_i,
  input  logic             ret_dir_i,
  input  logic             ret_mispred_i,
  output logic             hash_valid_o,
  output logic [IDX_W-1:0] hash_idx_o,
  output logic [TAG_W-1:0] hash_tag_o
);

  localparam int FT2_W = TAG_W - 1;
  // Bit position where the bit leaving the history re-enters each fold.
  localparam int OFF_I  = HIST_LEN % IDX_W;
  localparam int OFF_T1 = HIST_LEN % TAG_W;
  localparam int OFF_T2 = HIST_LEN % FT2_W;

  // Speculative set
  logic [HIST_LEN-1:0] s_hist, s_hist_push, s_hist_nxt;
  logic [IDX_W-1:0]    s_fi,   s_fi_push,   s_fi_nxt;
  logic [TAG_W-1:0]    s_ft1,  s_ft1_push,  s_ft1_nxt;
  logic [FT2_W-1:0]    s_ft2,  s_ft2_push,  s_ft2_nxt;
  // Architectural set
  logic [HIST_LEN-1:0] a_hist, a_hist_push, a_hist_nxt;
  logic [IDX_W-1:0]    a_fi,   a_fi_push,   a_fi_nxt;
  logic [TAG_W-1:0]    a_ft1,  a_ft1_push,  a_ft1_nxt;
  logic [FT2_W-1:0]    a_ft2,  a_ft2_push,  a_ft2_nxt;

  logic             flush;
  logic [IDX_W-1:0] fi_use;
  logic [TAG_W-1:0] ft1_use;
  logic [FT2_W-1:0] ft2_use;
  logic [IDX_W-1:0] idx_nxt;
  logic [TAG_W-1:0] tag_nxt;

`ifdef TAGE_HIST_DOMAIN_FLUSH_EN
  domain_t dom_r;

  // A lookup from a new domain wipes all history so nothing leaks across owners.
  assign flush = lookup_valid_i && (domain_i != dom_r);

  // Capture the owner domain of every lookup.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dom_r <= INIT;
    end else if (lookup_valid_i) begin
      dom_r <= domain_i;
    end else begin
      dom_r <= dom_r;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{pc_i[31:2*IDX_W+2], pc_i[1:0]};
`else
  assign flush = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{pc_i[31:2*IDX_W+2], pc_i[1:0], domain_i};
`endif

  // Push candidates: shift the history and rotate each fold, inserting the new
  // bit at position 0 and cancelling the outgoing bit at its wrapped position.
  always_comb begin
    s_hist_push = {s_hist[HIST_LEN-2:0], spec_dir_i};
    s_fi_push   = {s_fi[IDX_W-2:0], s_fi[IDX_W-1]} ^ {{(IDX_W-1){1'b0}}, spec_dir_i};
    s_ft1_push  = {s_ft1[TAG_W-2:0], s_ft1[TAG_W-1]} ^ {{(TAG_W-1){1'b0}}, spec_dir_i};
    s_ft2_push  = {s_ft2[FT2_W-2:0], s_ft2[FT2_W-1]} ^ {{(FT2_W-1){1'b0}}, spec_dir_i};
    s_fi_push[OFF_I]   = s_fi_push[OFF_I]   ^ s_hist[HIST_LEN-1];
    s_ft1_push[OFF_T1] = s_ft1_push[OFF_T1] ^ s_hist[HIST_LEN-1];
    s_ft2_push[OFF_T2] = s_ft2_push[OFF_T2] ^ s_hist[HIST_LEN-1];

    a_hist_push = {a_hist[HIST_LEN-2:0], ret_dir_i};
    a_fi_push   = {a_fi[IDX_W-2:0], a_fi[IDX_W-1]} ^ {{(IDX_W-1){1'b0}}, ret_dir_i};
    a_ft1_push  = {a_ft1[TAG_W-2:0], a_ft1[TAG_W-1]} ^ {{(TAG_W-1){1'b0}}, ret_dir_i};
    a_ft2_push  = {a_ft2[FT2_W-2:0], a_ft2[FT2_W-1]} ^ {{(FT2_W-1){1'b0}}, ret_dir_i};
    a_fi_push[OFF_I]   = a_fi_push[OFF_I]   ^ a_hist[HIST_LEN-1];
    a_ft1_push[OFF_T1] = a_ft1_push[OFF_T1] ^ a_hist[HIST_LEN-1];
    a_ft2_push[OFF_T2] = a_ft2_push[OFF_T2] ^ a_hist[HIST_LEN-1];
  end

  // Next-state selection: flush beats repair, repair beats a speculative push.
  always_comb begin
    a_hist_nxt = a_hist;
    a_fi_nxt   = a_fi;
    a_ft1_nxt  = a_ft1;
    a_ft2_nxt  = a_ft2;
    s_hist_nxt = s_hist;
    s_fi_nxt   = s_fi;
    s_ft1_nxt  = s_ft1;
    s_ft2_nxt  = s_ft2;
    if (flush) begin
      a_hist_nxt = '0;
      a_fi_nxt   = '0;
      a_ft1_nxt  = '0;
      a_ft2_nxt  = '0;
      s_hist_nxt = '0;
      s_fi_nxt   = '0;
      s_ft1_nxt  = '0;
      s_ft2_nxt  = '0;
    end else begin
      if (ret_valid_i) begin
        a_hist_nxt = a_hist_push;
        a_fi_nxt   = a_fi_push;
        a_ft1_nxt  = a_ft1_push;
        a_ft2_nxt  = a_ft2_push;
      end else begin
        a_hist_nxt = a_hist;
      end
      if (ret_valid_i && ret_mispred_i) begin
        s_hist_nxt = a_hist_push;
        s_fi_nxt   = a_fi_push;
        s_ft1_nxt  = a_ft1_push;
        s_ft2_nxt  = a_ft2_push;
      end else if (spec_push_i) begin
        s_hist_nxt = s_hist_push;
        s_fi_nxt   = s_fi_push;
        s_ft1_nxt  = s_ft1_push;
        s_ft2_nxt  = s_ft2_push;
      end else begin
        s_hist_nxt = s_hist;
      end
    end
  end

  // Hash from the speculative folds as they stand this cycle (zeroed on flush).
  always_comb begin
    fi_use  = s_fi;
    ft1_use = s_ft1;
    ft2_use = s_ft2;
    if (flush) begin
      fi_use  = '0;
      ft1_use = '0;
      ft2_use = '0;
    end else begin
      fi_use  = s_fi;
    end
    idx_nxt = pc_i[IDX_W+1:2] ^ pc_i[2*IDX_W+1:IDX_W+2] ^ fi_use;
    tag_nxt = pc_i[TAG_W+1:2] ^ ft1_use ^ {ft2_use, 1'b0};
  end

  // History and fold registers for both sets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_hist <= '0;
      s_fi   <= '0;
      s_ft1  <= '0;
      s_ft2  <= '0;
      a_hist <= '0;
      a_fi   <= '0;
      a_ft1  <= '0;
      a_ft2  <= '0;
    end else begin
      s_hist <= s_hist_nxt;
      s_fi   <= s_fi_nxt;
      s_ft1  <= s_ft1_nxt;
      s_ft2  <= s_ft2_nxt;
      a_hist <= a_hist_nxt;
      a_fi   <= a_fi_nxt;
      a_ft1  <= a_ft1_nxt;
      a_ft2  <= a_ft2_nxt;
    end
  end

  // Registered hash outputs; index and tag hold when no lookup is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hash_valid_o <= 1'b0;
      hash_idx_o   <= '0;
      hash_tag_o   <= '0;
    end else begin
      hash_valid_o <= lookup_valid_i;
      if (lookup_valid_i) begin
        hash_idx_o <= idx_nxt;
        hash_tag_o <= tag_nxt;
      end else begin
        hash_idx_o <= hash_idx_o;
        hash_tag_o <= hash_tag_o;
      end
    end
  end

endmodule

// File: doc/tage_hist_hash.md
# tage_hist_hash

Upstream index/tag generator for the TAGE tagged tables. Keeps a speculative and an architectural global branch history and, for each, three incrementally folded history registers (index fold, tag fold 1, tag fold 2). Each lookup produces a registered table index and partial tag from the PC and speculative folds; these feed the tagged table's index and tag inputs. On a retired mispredict, the speculative state is repaired from the architectural state.

## Interface
- `HIST_LEN`, 64: global history length in bits. Legal range is `TAG_W < HIST_LEN <= 256`.
- `IDX_W`, `` `TAGE_IDX_WIDTH ``: index width. Requires `2*IDX_W+2 <= 32`.
- `TAG_W`, 9: tag width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `lookup_valid_i` in 1: lookup request this cycle.
- `pc_i` in 32: lookup PC.
- `domain_i` in `domain_t`: owner domain of the current request.
- `spec_push_i` in 1: push the predicted direction into the speculative history.
- `spec_dir_i` in 1: predicted direction (1 = taken).
- `ret_valid_i` in 1: a branch retires this cycle.
- `ret_dir_i` in 1: resolved direction of the retiring branch.
- `ret_mispred_i` in 1: the retiring branch was mispredicted.
- `hash_valid_o` out 1: the hash outputs are valid.
- `hash_idx_o` out `IDX_W`: table index.
- `hash_tag_o` out `TAG_W`: table tag.

## Operation
- **State.** Two register sets, `S` (speculative) and `A` (architectural). Each set holds:
  - `hist[HIST_LEN-1:0]`
  - `fi[IDX_W-1:0]`
  - `ft1[TAG_W-1:0]`
  - `ft2[TAG_W-2:0]`
- **Push of bit `b`** into a set. With `out = hist[HIST_LEN-1]`:
  - `hist <= {hist[HIST_LEN-2:0], b}`.
  - For each fold `f` of width `W`: `f <= {f[W-2:0], f[W-1]} ^ b`, then bit `HIST_LEN % W` is XORed with `out`.
  - Invariant: each fold always equals the XOR of all `W`-bit chunks of `hist`. The chunks are taken from bit 0 upward, and the last chunk is zero-padded.
- **Hash on lookup.** Computed from `S` as it stands before this cycle's pushes.
  - `idx = pc_i[IDX_W+1:2] ^ pc_i[2*IDX_W+1:IDX_W+2] ^ fi`
  - `tag = pc_i[TAG_W+1:2] ^ ft1 ^ {ft2, 1'b0}`
- **Speculative push.** When `spec_push_i` is high, push `spec_dir_i` into `S`.
- **Retire.** When `ret_valid_i` is high, push `ret_dir_i` into `A`. If `ret_mispred_i` is also high, `S` is loaded with the post-push value of `A`; all three folds are copied as well.
- **Simultaneous events.**
  - Retire with mispredict in the same cycle as `spec_push_i`: the mispredict repair wins and the speculative push is dropped.
  - Retire without mispredict in the same cycle as `spec_push_i`: both updates happen independently.
  - `ret_mispred_i` high without `ret_valid_i`: ignored.
- **Datapath width.** All arithmetic is XOR or rotate; there is no carry logic. The `HIST_LEN % W` bit offsets are elaboration-time constants.

## Timing
- **Reset.** All `hist` and fold registers in both sets are 0. `hash_valid_o`, `hash_idx_o` and `hash_tag_o` are 0. The captured domain is `INIT`.
- **Lookup latency.** A lookup in cycle N drives `hash_valid_o = 1` with `hash_idx_o`/`hash_tag_o` in cycle N+1. `hash_valid_o` is 0 in any cycle following a cycle without a lookup. Outputs hold their last value when not valid.
- **Back-to-back lookups.** One lookup per cycle with no stall. A push in cycle N affects lookups from cycle N+1 onward.
- **State updates.** `S` and `A` updates take effect at the clock edge ending the cycle.
- **Reset mid-operation.** When `rst_ni` is asserted, all state clears immediately (asynchronous) and `hash_valid_o` drops without waiting for a clock edge. Any in-flight lookup is lost.

## Configuration
- **`TAGE_HIST_DOMAIN_FLUSH_EN` defined:**
  - The block registers `domain_i` on every lookup.
  - A lookup whose `domain_i` differs from the captured domain uses all-zero folds for its hash.
  - At the same edge, both `S` and `A` are cleared. The flush overrides any push or repair in that cycle, and the captured domain is updated.
  - This prevents cross-domain history leakage through index and tag aliasing.
- **Undefined:** `domain_i` is ignored and history is shared across domains.

## Test plan
- **Reset values.** Assert `rst_ni = 0` mid-run → all outputs 0 asynchronously. After release, lookup `pc_i = 0x0000_1000` → next cycle `hash_idx_o = 0x001`, `hash_tag_o = 0x000`, `hash_valid_o = 1` (with `IDX_W = 10`).
- **Single push.** `spec_push_i = 1`, `spec_dir_i = 1`, then lookup `pc_i = 0x0000_1000` → `hash_idx_o = 0x000`, `hash_tag_o = 0x003`. A lookup in the same cycle as the push still gives `0x001` / `0x000`.
- **Mispredict repair.** Three taken speculative pushes, then retire with `ret_dir_i = 0`, `ret_mispred_i = 1`, plus a simultaneous `spec_push_i`. Then lookup `0x0000_1000` → `hash_idx_o = 0x001`, `hash_tag_o = 0x000`, and `S.hist == A.hist == 0`.
- **Fold invariant across wrap.** 2000 random pushes (more than `HIST_LEN`) with random retires → after every cycle, each fold equals the chunk-XOR recompute of its `hist`, checked by a scoreboard for both `S` and `A`.
- **Domain flush (`TAGE_HIST_DOMAIN_FLUSH_EN`).** 5 taken pushes in domain D0, then lookup `0x0000_1000` in domain D1 → `hash_idx_o = 0x001`, `hash_tag_o = 0x000`, and both histories are 0 afterwards. Without the macro, the same stimulus gives the non-zero history hash.
- **Back-to-back.** 8 consecutive lookups with distinct PCs → 8 consecutive valid outputs, each matching the reference hash at 1-cycle latency.
